// File: rtl/apb_pad_cfg_pkg.sv
// Shared types, register offsets and bit indices for the APB pad configuration bank.
// Lock behaviour is selected in the top by the PAD_CFG_LOCK_EN macro.
package apb_pad_cfg_pkg;

    localparam int unsigned PAD_CFG_W = 6;

    typedef logic [PAD_CFG_W-1:0] pad_cfg_t;

    localparam logic [7:0] CFG_BASE   = 8'h00;
    localparam logic [7:0] CTRL_OFS   = 8'h30;
    localparam logic [7:0] STATUS_OFS = 8'h34;

    localparam int unsigned CTRL_APPLY_BIT  = 0;
    localparam int unsigned CTRL_LOCK_BIT   = 1;
    localparam int unsigned STATUS_PEND_BIT = 0;
    localparam int unsigned STATUS_LOCK_BIT = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    // Word index as decoded from PADDR[7:2].
    function automatic logic [5:0] word_idx(input logic [7:0] ofs);
        return ofs[7:2];
    endfunction

endpackage

// File: rtl/apb_pad_cfg_if.sv
// APB slave front end: three-state transfer FSM with one wait state, address capture,
// and registered PRDATA/PREADY/PSLVERR. Register semantics live in the top.
module apb_pad_cfg_if
    import apb_pad_cfg_pkg::*;
#(
    parameter int unsigned AW = 12
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [AW-1:0] paddr_i,
    input  logic [31:0]   pwdata_i,
    input  logic          pwrite_i,
    input  logic          psel_i,
    input  logic          penable_i,
    output logic [31:0]   prdata_o,
    output logic          pready_o,
    output logic          pslverr_o,
    output logic          wr_en_o,
    output logic          rd_en_o,
    output logic          write_o,
    output logic [5:0]    idx_o,
    output logic [31:0]   wdata_o,
    input  logic [31:0]   rdata_i,
    input  logic          err_i
);

    apb_state_e  state_q, state_d;
    logic [5:0]  idx_q, idx_d;
    logic        write_q, write_d;
    logic [31:0] wdata_q, wdata_d;
    logic        pready_q, pready_d;
    logic [31:0] prdata_q, prdata_d;
    logic        pslverr_q, pslverr_d;
    logic        unused_addr_s;

    assign unused_addr_s = ^{paddr_i[AW-1:8], paddr_i[1:0]};

    // Next-state and response computation; the response is registered so it appears with PREADY.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
        pready_d  = 1'b0;
        prdata_d  = 32'h0000_0000;
        pslverr_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (psel_i && !penable_i) begin
                    state_d = SETUP;
                    idx_d   = paddr_i[7:2];
                    write_d = pwrite_i;
                    wdata_d = pwdata_i;
                end else begin
                    state_d = IDLE;
                end
            end
            SETUP: begin
                if (psel_i && penable_i) begin
                    state_d   = ACCESS;
                    pready_d  = 1'b1;
                    pslverr_d = err_i;
                    prdata_d  = (err_i || write_q) ? 32'h0000_0000 : rdata_i;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM and response registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            idx_q     <= 6'd0;
            write_q   <= 1'b0;
            wdata_q   <= 32'h0000_0000;
            pready_q  <= 1'b0;
            prdata_q  <= 32'h0000_0000;
            pslverr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            pready_q  <= pready_d;
            prdata_q  <= prdata_d;
            pslverr_q <= pslverr_d;
        end
    end

    // Writes land on the edge that ends the PREADY cycle, and only if no error was signalled.
    assign wr_en_o   = (state_q == ACCESS) && psel_i && penable_i && write_q && !pslverr_q;
    assign rd_en_o   = (state_q == SETUP) && psel_i && penable_i && !write_q;
    assign write_o   = write_q;
    assign idx_o     = idx_q;
    assign wdata_o   = wdata_q;
    assign prdata_o  = prdata_q;
    assign pready_o  = pready_q;
    assign pslverr_o = pslverr_q;

endmodule

// File: rtl/apb_pad_cfg.sv
// Pad configuration bank: shadow registers committed atomically into the active set by APPLY.
// Define PAD_CFG_LOCK_EN to implement the sticky CTRL.LOCK write protection.
module apb_pad_cfg
    import apb_pad_cfg_pkg::*;
#(
    parameter int unsigned N_PADS         = 48,
    parameter int unsigned CFG_W          = PAD_CFG_W,
    parameter int unsigned APB_ADDR_WIDTH = 12
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]               PWDATA,
    input  logic                      PWRITE,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    output logic [31:0]               PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    output logic [N_PADS-1:0][CFG_W-1:0] pad_cfg_o,
    output logic                      cfg_update_o
);

    localparam int unsigned N_WORDS    = (N_PADS + 3) / 4;
    localparam logic [5:0]  N_WORDS_L  = 6'(N_WORDS);
    localparam logic [5:0]  CFG_IDX    = word_idx(CFG_BASE);
    localparam logic [5:0]  CTRL_IDX   = word_idx(CTRL_OFS);
    localparam logic [5:0]  STATUS_IDX = word_idx(STATUS_OFS);

    logic        wr_en_s, rd_en_s, write_s, err_s;
    logic [5:0]  idx_s, rel_idx_s;
    logic [31:0] wdata_s, rdata_s;
    logic        is_cfg_s, is_ctrl_s, is_status_s, pending_s;
    logic        unused_wdata_s;

    logic [N_PADS-1:0][CFG_W-1:0] shadow_q, shadow_d;
    logic [N_PADS-1:0][CFG_W-1:0] active_q, active_d;
    logic apply_q, apply_d;
    logic update_q, update_d;
    logic lock_q, lock_d;

    apb_pad_cfg_if #(.AW(APB_ADDR_WIDTH)) u_if (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .paddr_i   (PADDR),
        .pwdata_i  (PWDATA),
        .pwrite_i  (PWRITE),
        .psel_i    (PSEL),
        .penable_i (PENABLE),
        .prdata_o  (PRDATA),
        .pready_o  (PREADY),
        .pslverr_o (PSLVERR),
        .wr_en_o   (wr_en_s),
        .rd_en_o   (rd_en_s),
        .write_o   (write_s),
        .idx_o     (idx_s),
        .wdata_o   (wdata_s),
        .rdata_i   (rdata_s),
        .err_i     (err_s)
    );

    assign unused_wdata_s = ^wdata_s;
    assign rel_idx_s      = idx_s - CFG_IDX;

    // Address decode, error classification and read mux.
    always_comb begin
        is_ctrl_s   = (idx_s == CTRL_IDX);
        is_status_s = (idx_s == STATUS_IDX);
        is_cfg_s    = !is_ctrl_s && !is_status_s && (rel_idx_s < N_WORDS_L);
        pending_s   = (shadow_q != active_q);
        err_s = !(is_cfg_s || is_ctrl_s || is_status_s)
              || (write_s && is_status_s)
              || (lock_q && write_s && (is_cfg_s || (is_ctrl_s && wdata_s[CTRL_APPLY_BIT])));
        rdata_s = 32'h0000_0000;
        if (rd_en_s && is_cfg_s) begin
            for (int p = 0; p < int'(N_PADS); p++) begin
                if (6'(p / 4) == rel_idx_s) begin
                    rdata_s[8*(p%4) +: CFG_W] = shadow_q[p];
                end else begin
                    rdata_s[8*(p%4) +: CFG_W] = rdata_s[8*(p%4) +: CFG_W];
                end
            end
        end else if (rd_en_s && is_status_s) begin
            rdata_s[STATUS_PEND_BIT] = pending_s;
            rdata_s[STATUS_LOCK_BIT] = lock_q;
        end else begin
            rdata_s = 32'h0000_0000;
        end
    end

    // Shadow writes, the two-step apply (arm at E, copy at E+1) and the lock bit.
    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        apply_d  = 1'b0;
        update_d = 1'b0;
        for (int p = 0; p < int'(N_PADS); p++) begin
            if (wr_en_s && is_cfg_s && (6'(p / 4) == rel_idx_s)) begin
                shadow_d[p] = wdata_s[8*(p%4) +: CFG_W];
            end else begin
                shadow_d[p] = shadow_q[p];
            end
        end
        if (apply_q) begin
            active_d = shadow_q;
            update_d = 1'b1;
        end else begin
            apply_d = wr_en_s && is_ctrl_s && wdata_s[CTRL_APPLY_BIT];
        end
`ifdef PAD_CFG_LOCK_EN
        lock_d = lock_q || (wr_en_s && is_ctrl_s && wdata_s[CTRL_LOCK_BIT]);
`else
        lock_d = 1'b0;
`endif
    end

    // Register bank state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shadow_q <= '0;
            active_q <= '0;
            apply_q  <= 1'b0;
            update_q <= 1'b0;
            lock_q   <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            apply_q  <= apply_d;
            update_q <= update_d;
            lock_q   <= lock_d;
        end
    end

    assign pad_cfg_o    = active_q;
    assign cfg_update_o = update_q;

endmodule
